// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants and segment decode for the scan multiplexer
package sseg_pkg;

    // Supported digit counts
    localparam int MIN_DIGITS = 1;
    localparam int MAX_DIGITS = 8;

    // All segments off (active-low pins)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g pattern for a nibble; A-F only shown in hex mode
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = hex_mode ? 7'h08 : SEG_BLANK;
            4'hB: s = hex_mode ? 7'h60 : SEG_BLANK;
            4'hC: s = hex_mode ? 7'h31 : SEG_BLANK;
            4'hD: s = hex_mode ? 7'h42 : SEG_BLANK;
            4'hE: s = hex_mode ? 7'h30 : SEG_BLANK;
            default: s = hex_mode ? 7'h38 : SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// rtl/sseg_scan_mux_if.sv - display value load handshake between datapath and driver
interface sseg_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  load_ack;

    // Datapath side: offers a new value, sees when it reaches the display
    modport master (
        output digits_in,
        output dp_in,
        output load,
        input  load_ack
    );

    // Driver side
    modport slave (
        input  digits_in,
        input  dp_in,
        input  load,
        output load_ack
    );
endinterface

// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - combinational nibble to active-low segment decoder
module sseg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanking overrides the decoded glyph
    always_comb begin
        seg = blank ? SEG_BLANK : hex_to_seg(nibble, hex_mode);
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - time-multiplexed common-anode 7-segment driver with tear-free updates
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 2**16,
    parameter int BRIGHT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    sseg_scan_mux_if.slave      bus,
    input  logic                hex_mode,
    input  logic                lz_blank,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [N_DIGITS-1:0] an,
    output logic                frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  boundary;

    logic [4*N_DIGITS-1:0] staging_digits;
    logic [N_DIGITS-1:0]   staging_dp;
    logic [4*N_DIGITS-1:0] shadow_digits;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  pending;
    logic                  load_ack_r;

    logic [N_DIGITS-1:0]   lz_vec;
    logic                  upper_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [6:0]            seg_next;
    logic [N_DIGITS-1:0]   an_next;
    logic [BRIGHT_W-1:0]   ph;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign ph       = presc[BRIGHT_W-1:0];
    assign bus.load_ack = load_ack_r;

    // Slot prescaler and digit index; index steps once per slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Double buffer: loads land in staging, shadow only changes at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_digits <= '0;
            staging_dp     <= '0;
            shadow_digits  <= '0;
            shadow_dp      <= '0;
            pending        <= 1'b0;
            load_ack_r     <= 1'b0;
        end else if (boundary) begin
            // A load on the boundary itself bypasses staging so it is not deferred a frame
            if (bus.load) begin
                shadow_digits  <= bus.digits_in;
                shadow_dp      <= bus.dp_in;
                staging_digits <= bus.digits_in;
                staging_dp     <= bus.dp_in;
            end else if (pending) begin
                shadow_digits <= staging_digits;
                shadow_dp     <= staging_dp;
            end
            pending    <= 1'b0;
            load_ack_r <= bus.load || pending;
        end else begin
            load_ack_r <= 1'b0;
            if (bus.load) begin
                staging_digits <= bus.digits_in;
                staging_dp     <= bus.dp_in;
                pending        <= 1'b1;
            end
        end
    end

    // Leading-zero map and selection of the active digit from the shadow copy
    always_comb begin
        upper_zero = 1'b1;
        lz_vec     = '0;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_digits[4*i +: 4] == 4'h0);
            lz_vec[i]  = (i != 0) && upper_zero;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = shadow_digits[4*i +: 4];
                cur_dp  = shadow_dp[i];
                cur_lz  = lz_vec[i];
            end
        end
    end

    sseg_decoder u_decoder (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .blank    (lz_blank && cur_lz),
        .seg      (seg_next)
    );

    // PWM gates only the anode; segments keep tracking the slot
    always_comb begin
        an_next = (ph < brightness) ? ~(N_DIGITS'(1) << idx) : '1;
    end

    // Registered pin drivers and frame marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_next;
            dp          <= ~cur_dp;
            an          <= an_next;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - scoreboard bench for the 4-digit scan multiplexer
module tb_sseg_scan_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic       hex_mode;
    logic       lz_blank;
    logic [1:0] brightness;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb[$];

    sseg_scan_mux_if #(.N_DIGITS(4)) bus ();

    sseg_scan_mux #(
        .N_DIGITS    (4),
        .REFRESH_DIV (16),
        .BRIGHT_W    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .hex_mode    (hex_mode),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n, input logic hx);
        case (n)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;
            4'hA: return hx ? 7'h08 : 7'h7F;
            4'hB: return hx ? 7'h60 : 7'h7F;
            4'hC: return hx ? 7'h31 : 7'h7F;
            4'hD: return hx ? 7'h42 : 7'h7F;
            4'hE: return hx ? 7'h30 : 7'h7F;
            default: return hx ? 7'h38 : 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.digits_in = v;
        bus.dp_in     = d;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    // Returns at a negedge with frame_start high; checks the ack seen with it
    task automatic wait_frame(input logic exp_ack, output int waited);
        waited = 0;
        while (frame_start !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
        chk("load_ack_at_frame", {31'd0, bus.load_ack}, {31'd0, exp_ack});
    endtask

    // Called at a frame_start negedge; checks the next 64 pin states
    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] d);
        logic [11:0] got;
        logic [11:0] exp;
        logic [3:0]  an_e;
        logic [6:0]  seg_e;
        for (int di = 0; di < 4; di++) begin
            for (int p = 0; p < 16; p++) begin
                an_e = ((p % 4) < int'(brightness)) ? ~(4'b0001 << di) : 4'hF;
                if (lz_blank && di > 0 && (v >> (4 * di)) == 16'h0)
                    seg_e = 7'h7F;
                else
                    seg_e = ref_seg(v[4*di +: 4], hex_mode);
                sb.push_back({an_e, seg_e, ~d[di]});
            end
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            got = {an, seg, dp};
            exp = sb.pop_front();
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s[%0d]: observed an/seg/dp %h expected %h", tag, k, got, exp);
            end
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        hex_mode = 1'b1;
        lz_blank = 1'b0;
        brightness = 2'd3;
        bus.digits_in = '0;
        bus.dp_in = '0;
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_dp", {31'd0, dp}, 32'd1);
        chk("reset_ack", {31'd0, bus.load_ack}, 32'd0);
        chk("reset_frame_start", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;

        // Basic load and scan
        do_load(16'h1234, 4'b0000);
        wait_frame(1'b1, w);
        check_frame("scan_1234", 16'h1234, 4'b0000);
        wait_frame(1'b0, w);

        // Last of two loads wins, single ack; leading-zero blanking
        do_load(16'h0012, 4'b0000);
        @(negedge clk);
        do_load(16'h0034, 4'b0000);
        wait_frame(1'b1, w);
        check_frame("last_load_wins", 16'h0034, 4'b0000);
        wait_frame(1'b0, w);
        lz_blank = 1'b1;
        check_frame("lz_0034", 16'h0034, 4'b0000);
        wait_frame(1'b0, w);
        do_load(16'h0000, 4'b0000);
        wait_frame(1'b1, w);
        check_frame("lz_0000", 16'h0000, 4'b0000);
        wait_frame(1'b0, w);
        lz_blank = 1'b0;

        // Load on the exact boundary cycle
        repeat (63) @(negedge clk);
        do_load(16'h5678, 4'b0000);
        wait_frame(1'b1, w);
        chk("boundary_ack_latency", w, 32'd0);
        check_frame("boundary_load", 16'h5678, 4'b0000);
        wait_frame(1'b0, w);

        // Hex mode and decimal points
        do_load(16'h000A, 4'b0100);
        wait_frame(1'b1, w);
        check_frame("hex_on", 16'h000A, 4'b0100);
        wait_frame(1'b0, w);
        hex_mode = 1'b0;
        check_frame("hex_off", 16'h000A, 4'b0100);
        wait_frame(1'b0, w);
        hex_mode = 1'b1;

        // Brightness extremes
        brightness = 2'd0;
        check_frame("bright0", 16'h000A, 4'b0100);
        wait_frame(1'b0, w);
        brightness = 2'd1;
        check_frame("bright1", 16'h000A, 4'b0100);
        wait_frame(1'b0, w);
        brightness = 2'd3;

        // Mid-scan reset drops a pending load
        do_load(16'h9999, 4'b1111);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_dp", {31'd0, dp}, 32'd1);
        chk("midrst_ack", {31'd0, bus.load_ack}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_an", {28'd0, an}, 32'hE);
        chk("post_rst_seg", {25'd0, seg}, 32'h01);
        wait_frame(1'b0, w);
        check_frame("post_rst_frame", 16'h0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
